// File: rtl/bin2dec_seq_display_if.sv
// Handshake and result bundle between a requester and the bin2dec_seq_display converter.
// The requester drives the operand and start. The converter returns status and the two BCD digits.
interface bin2dec_seq_display_if;
  logic [5:0] SW;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] ten;
  logic [3:0] units;

  modport master (output SW, start, input busy, done, ten, units);
  modport slave  (input SW, start, output busy, done, ten, units);
endinterface

// File: rtl/bin2dec_seq_display.sv
// Sequential 6-bit binary to two-digit BCD converter (shift-add-3) driving the HEX1:HEX0 pair.
// Digits and segment patterns are registered and hold until the next conversion completes.
module bin2dec_seq_display #(
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  bin2dec_seq_display_if.slave  bus,
  output logic [0:6]            HEX0,
  output logic [0:6]            HEX1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_ZERO  = 7'b0000001;
  localparam logic [0:6] HEX1_RST  = BLANK_LEADING_ZERO ? SEG_BLANK : SEG_ZERO;

  // Active-low a..g pattern for one digit. Codes 10..15 are unreachable and shown blank.
  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // The nibble is at most 9 here, so the 4-bit sum never wraps.
  function automatic logic [3:0] add3(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

  logic [1:0]  state_r;
  logic [2:0]  cnt_r;
  logic [13:0] sh_r;
  logic        busy_r;
  logic        done_r;
  logic [3:0]  ten_r;
  logic [3:0]  units_r;
  logic [0:6]  hex0_r;
  logic [0:6]  hex1_r;

  logic [13:0] adj_s;
  logic [13:0] shifted_s;

  // One double-dabble step: adjust both BCD nibbles, then shift left.
  always_comb begin
    adj_s        = sh_r;
    adj_s[13:10] = add3(sh_r[13:10]);
    adj_s[9:6]   = add3(sh_r[9:6]);
    shifted_s    = {adj_s[12:0], 1'b0};
  end

  // Control FSM, shift datapath and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 3'd0;
      sh_r    <= 14'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ten_r   <= 4'd0;
      units_r <= 4'd0;
      hex0_r  <= SEG_ZERO;
      hex1_r  <= HEX1_RST;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            sh_r    <= {8'd0, bus.SW};
            cnt_r   <= 3'd6;
            state_r <= S_SHIFT;
            busy_r  <= 1'b1;
          end
        end
        S_SHIFT: begin
          sh_r  <= shifted_s;
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
            ten_r   <= shifted_s[13:10];
            units_r <= shifted_s[9:6];
            hex0_r  <= seg7(shifted_s[9:6]);
            if (BLANK_LEADING_ZERO && (shifted_s[13:10] == 4'd0)) begin
              hex1_r <= SEG_BLANK;
            end else begin
              hex1_r <= seg7(shifted_s[13:10]);
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.ten   = ten_r;
  assign bus.units = units_r;
  assign HEX0      = hex0_r;
  assign HEX1      = hex1_r;

endmodule

// File: tb/tb_bin2dec_seq_display.sv
// Directed bench for bin2dec_seq_display: two instances (leading-zero blanking on and off)
// share clock, reset and stimulus. Expected digits and segments come from constants and /, %.
module tb_bin2dec_seq_display;
  logic clk;
  logic reset;
  logic [0:6] hex0_a, hex1_a, hex0_b, hex1_b;
  int total;
  int bad;
  logic [0:6] seg_tab [0:9];
  localparam logic [0:6] BLANK = 7'b1111111;

  bin2dec_seq_display_if a_if ();
  bin2dec_seq_display_if b_if ();

  assign b_if.SW    = a_if.SW;
  assign b_if.start = a_if.start;

  bin2dec_seq_display dut_a (
    .CLOCK_50(clk), .reset(reset), .bus(a_if.slave), .HEX0(hex0_a), .HEX1(hex1_a)
  );
  bin2dec_seq_display #(.BLANK_LEADING_ZERO(1'b0)) dut_b (
    .CLOCK_50(clk), .reset(reset), .bus(b_if.slave), .HEX0(hex0_b), .HEX1(hex1_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Check both instances against value/10 and value%10.
  task automatic chk_result(input string tag, input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    chk({tag, ".ten"},   32'(a_if.ten),   32'(t));
    chk({tag, ".units"}, 32'(a_if.units), 32'(u));
    chk({tag, ".hex0"},  32'(hex0_a),     32'(seg_tab[u]));
    chk({tag, ".hex1"},  32'(hex1_a),     (t == 4'd0) ? 32'(BLANK) : 32'(seg_tab[t]));
    chk({tag, ".b.ten"}, 32'(b_if.ten),   32'(t));
    chk({tag, ".b.hex0"}, 32'(hex0_b),    32'(seg_tab[u]));
    chk({tag, ".b.hex1"}, 32'(hex1_b),    32'(seg_tab[t]));
  endtask

  // Start one conversion at a negedge and follow it until done, checking timing and result.
  task automatic convert(input string tag, input int v, input bit full);
    int n;
    a_if.SW    = 6'(v);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    n = 0;
    while (a_if.done !== 1'b1 && n < 20) begin
      if (full) chk({tag, ".busy_during"}, 32'(a_if.busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd6);
    if (full) chk({tag, ".busy_at_done"}, 32'(a_if.busy), 32'd1);
    chk_result(tag, v);
    @(negedge clk);
    chk({tag, ".done_low"}, 32'(a_if.done), 32'd0);
    if (full) chk({tag, ".busy_low"}, 32'(a_if.busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"},   32'(a_if.busy),  32'd0);
    chk({tag, ".done"},   32'(a_if.done),  32'd0);
    chk({tag, ".ten"},    32'(a_if.ten),   32'd0);
    chk({tag, ".units"},  32'(a_if.units), 32'd0);
    chk({tag, ".hex0"},   32'(hex0_a),     32'h01);
    chk({tag, ".hex1"},   32'(hex1_a),     32'h7f);
    chk({tag, ".b.hex1"}, 32'(hex1_b),     32'h01);
  endtask

  initial begin
    int dones;
    int first_done;
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    a_if.start = 1'b0;
    a_if.SW    = 6'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    convert("sw63", 63, 1'b1);
    convert("sw9", 9, 1'b1);
    convert("sw0", 0, 1'b1);

    // A start pulse during SHIFT must be ignored, and SW changes must not leak in.
    a_if.SW = 6'd42; a_if.start = 1'b1;
    dones = 0; first_done = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) a_if.start = 1'b0;
      if (k == 3) begin a_if.SW = 6'd17; a_if.start = 1'b1; end
      if (k == 4) a_if.start = 1'b0;
      if (a_if.done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
    end
    chk("ignore.dones", 32'(dones), 32'd1);
    chk("ignore.when", 32'(first_done), 32'd7);
    chk_result("ignore", 42);

    // Reset mid-conversion discards the run and forces reset values at once.
    a_if.SW = 6'd55; a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (a_if.done === 1'b1 || a_if.busy === 1'b1) dones++;
    end
    chk("midreset.idle", 32'(dones), 32'd0);

    // start held high: one conversion every 8 cycles, SW resampled at each accept.
    a_if.SW = 6'd10; a_if.start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) a_if.SW = 6'd37;
      if (a_if.done === 1'b1) begin
        dones++;
        if (k == 7) chk_result("held1", 10);
        else if (k == 15) chk_result("held2", 37);
        else chk("held.done_at", 32'(k), 32'd0);
      end
    end
    a_if.start = 1'b0;
    chk("held.dones", 32'(dones), 32'd2);
    repeat (3) @(negedge clk);

    for (int v = 0; v < 64; v++) begin
      convert("sweep", v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin2dec_seq_display.md
# bin2dec_seq_display

Sequential 6-bit binary to two-digit decimal converter and display controller for the DE-board 7-segment pair HEX1:HEX0. It replaces the divide/modulo datapath with a shift-add-3 (double-dabble) datapath that an FSM steps through under a start/busy/done handshake. Results are held in registers and drive the active-low 7-segment outputs until the next conversion completes.

## Interface
- BLANK_LEADING_ZERO, default 1: when 1, HEX1 is blanked (7'b1111111) while ten == 0.
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- SW  in  6  binary operand, 0..63; sampled only on the accept edge.
- start  in  1  conversion request, level-sampled in IDLE.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  high for exactly one cycle (DONE state).
- ten  out  4  registered tens digit, 0..6.
- units  out  4  registered units digit, 0..9.
- HEX0  out  [0:6]  active-low segments a..g for units; index 0 = a, 6 = g.
- HEX1  out  [0:6]  active-low segments a..g for ten, or blank.

## Operation
- Reset values: state IDLE, busy 0, done 0, ten 0, units 0, shift count 0, shift register 0, HEX0 7'b0000001, HEX1 7'b1111111 (BLANK_LEADING_ZERO = 1) or 7'b0000001 (= 0).
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start == 1, accept: load 14-bit shift register {8'b0, SW}, count = 6, go to SHIFT. Otherwise stay.
- SHIFT: each cycle, add 3 to each BCD nibble (bits 13:10, 9:6) that is >= 5, then shift the whole register left by 1; decrement count; on the edge where count reaches 0, go to DONE.
- DONE: done = 1; next edge returns to IDLE.
- Output registers (ten, units, HEX0, HEX1) load on the final SHIFT edge with the completed result, so they are valid in the same cycle that done = 1. They hold that value until the next completed conversion.
- Segment codes [0:6], active-low: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100. Nibble values 10..15 cannot occur; decode them as blank.
- start is ignored in SHIFT and DONE; no queuing.
- Changes on SW after the accept edge do not affect the running conversion.
- Width rule: the nibble adjust is 4-bit with no carry-out. A nibble is at most 9 before adjust, so the result never exceeds 12.

## Timing
- Accept at edge E0. busy rises after E0. Shifts occur at E1..E6. The output registers update at E6, and done/busy are high after E6. At E7 the FSM is back in IDLE with busy and done low.
- Latency: results are visible 6 edges after accept.
- With start held high, the next accept is at E8, giving one conversion per 8 cycles.
- Reset asserted mid-conversion: all registers return to their reset values asynchronously and the conversion is discarded. Conversion resumes only on an accept after reset deasserts.
- Reset and start asserted together: reset wins.

## Test plan
- Reset: assert reset with start = 0 -> busy 0, done 0, ten 0, units 0, HEX0 0000001, HEX1 1111111.
- SW = 63, start pulse -> busy for 7 cycles, done for 1 cycle after E6, ten 6, units 3, HEX1 0100000, HEX0 0000110.
- SW = 9, then SW = 0 -> first: ten 0, units 9, HEX1 blank, HEX0 0000100. Second: HEX0 0000001, HEX1 blank. Repeat with BLANK_LEADING_ZERO = 0 -> HEX1 0000001.
- SW = 42, start at E0; at E3 set SW = 17 and pulse start -> result ten 4, units 2, no second conversion, done pulses once.
- Start SW = 55, then assert reset at E3 -> outputs at reset values immediately; after release with start = 0 -> stays IDLE, done never pulses.
- start held high, SW = 10 then SW = 37 presented before E8 -> done pulses at E6 and E14, results 1/0 then 3/7. Exhaustive sweep 0..63 matches value/10 and value%10.
